sv_seq: RTL and testbench

//  Micro-program sequencer directly upstream of the signature execution unit (sv_ex).

---
 rtl/sv_seq.sv | 215 +++++++++++++++++++++
 tb/tb_sv_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_seq.sv
// Micro-program sequencer feeding the signature execution unit.
// Loads a program RAM, then fetches and decodes it, issuing EXEC payloads
// with a single-cycle strobe and holding each word until the unit is idle.
module sv_seq #(
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [17:0]       prog_data_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic              ex_v_o,
  output logic [14:0]       ex_i_o,
  input  logic              ex_ready_i,
  input  logic              ex_comp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              abort_i
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, SETTLE, WAIT_EX, DONE
  } state_t;

  localparam logic [2:0] OP_EXEC   = 3'd0;
  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_BRZ    = 3'd2;
  localparam logic [2:0] OP_BRNZ   = 3'd3;
  localparam logic [2:0] OP_SETCNT = 3'd4;
  localparam logic [2:0] OP_LOOP   = 3'd5;
  localparam logic [2:0] OP_HALT   = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  // Depth widened by one bit so targets can be range-checked for
  // non-power-of-two depths; the last legal PC stops the increment.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

  logic [17:0]       prog_mem [PROG_DEPTH];
  logic [17:0]       ir;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [14:0]       cnt, cnt_d;
  logic [14:0]       ex_i_d;
  logic              ex_v_d;
  logic              err_d;
  logic              abort_pend, abort_pend_d;
  logic              do_jump, do_advance;

  logic [2:0]        opcode;
  logic [14:0]       payload;
  logic [ADDR_W-1:0] target;
  logic              target_bad;
  logic              pc_at_end;
  logic [14:0]       cnt_dec;

  assign opcode     = ir[17:15];
  assign payload    = ir[14:0];
  assign target     = payload[ADDR_W-1:0];
  assign target_bad = {1'b0, target} >= DEPTH_X;
  assign pc_at_end  = (pc == LAST_PC);
  assign cnt_dec    = cnt - 15'd1;

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);
  assign pc_o   = pc;

  // Program RAM: writes only while idle, synchronous read of the PC in FETCH.
  always_ff @(posedge clk) begin
    if (prog_we_i && state == IDLE) begin
      prog_mem[prog_addr_i] <= prog_data_i;
    end
    if (state == FETCH) begin
      ir <= prog_mem[pc];
    end
  end

  // State and architectural registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state      <= IDLE;
      pc         <= '0;
      cnt        <= '0;
      ex_i_o     <= '0;
      ex_v_o     <= 1'b0;
      err_o      <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      cnt        <= cnt_d;
      ex_i_o     <= ex_i_d;
      ex_v_o     <= ex_v_d;
      err_o      <= err_d;
      abort_pend <= abort_pend_d;
    end
  end

  // Next-state logic: decode, issue handshake, abort handling, PC update.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    cnt_d        = cnt;
    ex_i_d       = ex_i_o;
    ex_v_d       = 1'b0;
    err_d        = err_o;
    abort_pend_d = abort_pend;
    do_jump      = 1'b0;
    do_advance   = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          pc_d         = start_addr_i;
          err_d        = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        state_d = abort_i ? DONE : DECODE;
      end
      DECODE: begin
        if (abort_i) begin
          state_d = DONE;
        end else begin
          case (opcode)
            OP_EXEC: begin
              ex_i_d  = payload;
              state_d = ISSUE;
            end
            OP_JMP:  do_jump = 1'b1;
            OP_BRZ: begin
              if (!ex_comp_i) do_jump = 1'b1;
              else            do_advance = 1'b1;
            end
            OP_BRNZ: begin
              if (ex_comp_i) do_jump = 1'b1;
              else           do_advance = 1'b1;
            end
            OP_SETCNT: begin
              cnt_d      = payload;
              do_advance = 1'b1;
            end
            OP_LOOP: begin
              cnt_d = cnt_dec;
              if (cnt_dec != 15'd0) do_jump = 1'b1;
              else                  do_advance = 1'b1;
            end
            OP_HALT: state_d = DONE;
            OP_ILL: begin
              err_d   = 1'b1;
              state_d = DONE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          endcase
        end
      end
      ISSUE: begin
        if (abort_i) begin
          state_d = DONE;
        end else if (ex_ready_i) begin
          ex_v_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_i) abort_pend_d = 1'b1;
        state_d = WAIT_EX;
      end
      WAIT_EX: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (ex_ready_i) begin
          if (abort_pend || abort_i) state_d = DONE;
          else                       do_advance = 1'b1;
        end
      end
      DONE: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_jump) begin
      if (target_bad) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        pc_d    = target;
        state_d = FETCH;
      end
    end

    if (do_advance) begin
      if (pc_at_end) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        pc_d    = pc + 1'b1;
        state_d = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_sv_seq.sv
// Self-checking bench for sv_seq: directed programs plus random programs,
// checked against an instruction-level interpreter and an execution-unit model.
module tb_sv_seq;

  localparam int PROG_DEPTH = 256;
  localparam int ADDR_W     = 8;

  localparam logic [2:0] OP_EXEC   = 3'd0;
  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_BRZ    = 3'd2;
  localparam logic [2:0] OP_BRNZ   = 3'd3;
  localparam logic [2:0] OP_SETCNT = 3'd4;
  localparam logic [2:0] OP_LOOP   = 3'd5;
  localparam logic [2:0] OP_HALT   = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  logic              clk = 1'b0;
  logic              areset;
  logic              prog_we_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [17:0]       prog_data_i;
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic              ex_v_o;
  logic [14:0]       ex_i_o;
  logic              ex_ready_i;
  logic              ex_comp_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W-1:0] pc_o;
  logic              abort_i;

  sv_seq #(.PROG_DEPTH(PROG_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .areset       (areset),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .ex_v_o       (ex_v_o),
    .ex_i_o       (ex_i_o),
    .ex_ready_i   (ex_ready_i),
    .ex_comp_i    (ex_comp_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .pc_o         (pc_o),
    .abort_i      (abort_i)
  );

  initial forever #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Program image as the bench believes it is loaded
  logic [17:0] mem_model [PROG_DEPTH];
  logic [14:0] m_cnt;
  logic [14:0] exp_words [$];
  logic        exp_err;
  logic [7:0]  exp_pc;

  // Execution-unit model state
  int  unit_lat;
  int  busy_left;
  bit  drop_pend;
  int  stall_left;
  int  rose_cyc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [17:0] d);
    @(negedge clk);
    prog_we_i   = 1'b1;
    prog_addr_i = a;
    prog_data_i = d;
    mem_model[a] = d;
    @(negedge clk);
    prog_we_i = 1'b0;
  endtask

  // Instruction-level interpreter: list of issued words, final error and PC
  task automatic modelRun(input logic [7:0] s, input bit comp);
    int pc;
    bit stop;
    bit adv;
    int steps;
    logic [2:0]  op;
    logic [14:0] pl;
    pc = s; stop = 0; steps = 0;
    exp_words.delete();
    exp_err = 1'b0;
    while (!stop && steps < 20000) begin
      op = mem_model[pc][17:15];
      pl = mem_model[pc][14:0];
      adv = 0;
      steps++;
      case (op)
        OP_EXEC:   begin exp_words.push_back(pl); adv = 1; end
        OP_JMP:    pc = int'(pl[7:0]);
        OP_BRZ:    if (!comp) pc = int'(pl[7:0]); else adv = 1;
        OP_BRNZ:   if (comp)  pc = int'(pl[7:0]); else adv = 1;
        OP_SETCNT: begin m_cnt = pl; adv = 1; end
        OP_LOOP: begin
          m_cnt = m_cnt - 15'd1;
          if (m_cnt != 15'd0) pc = int'(pl[7:0]); else adv = 1;
        end
        OP_HALT:   stop = 1;
        default:   begin exp_err = 1'b1; stop = 1; end
      endcase
      if (adv) begin
        if (pc == PROG_DEPTH - 1) begin exp_err = 1'b1; stop = 1; end
        else pc++;
      end
    end
    exp_pc = 8'(pc);
  endtask

  // Unit model: ready falls after the edge that samples v_i, stays low unit_lat cycles
  task automatic unitTick(input int cyc);
    logic prev;
    prev = ex_ready_i;
    if (drop_pend) begin
      drop_pend = 0;
      busy_left = unit_lat;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (ex_v_o) drop_pend = 1;
    if (stall_left > 0) stall_left--;
    ex_ready_i = (busy_left == 0) && (stall_left == 0);
    if (!prev && ex_ready_i) rose_cyc = cyc;
  endtask

  task automatic applyReset();
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    areset = 1'b1;
    busy_left = 0; drop_pend = 0; stall_left = 0;
    ex_ready_i = 1'b1;
    m_cnt = '0;
  endtask

  // One program run: start, watch every cycle, check issues and completion
  task automatic applyStimulus(input logic [7:0] s, input bit comp, input int lat, input int stall,
                               input bit abort_mode, input bit wr_en, input logic [7:0] wa,
                               input logic [17:0] wd, input bit noise);
    int n_exp;
    int issued;
    bit got_done;
    bit abort_fired;
    logic [14:0] exp_arr [$];
    logic [14:0] last_word;
    if (wr_en) mem_model[wa] = wd;
    modelRun(s, comp);
    exp_arr = exp_words;
    n_exp = abort_mode ? 1 : exp_arr.size();
    issued = 0; got_done = 0; abort_fired = 0; last_word = '0;
    unit_lat = lat; busy_left = 0; drop_pend = 0; stall_left = stall;
    ex_ready_i = (stall == 0);
    ex_comp_i = comp;
    rose_cyc = -100;
    @(negedge clk);
    start_i = 1'b1; start_addr_i = s;
    prog_we_i = wr_en; prog_addr_i = wa; prog_data_i = wd;
    @(negedge clk);
    start_i = 1'b0; prog_we_i = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (drop_pend || busy_left > 0) checkOutput("hold_word", ex_i_o, last_word);
      if (ex_v_o) begin
        checkOutput("issue_idle", ex_ready_i && !drop_pend, 1);
        if (issued < n_exp) checkOutput("issue_word", ex_i_o, exp_arr[issued]);
        issued++;
        last_word = ex_i_o;
      end
      if (done_o) begin
        got_done = 1;
        checkOutput("done_err", err_o, exp_err);
        if (!abort_mode) checkOutput("done_pc", pc_o, exp_pc);
        checkOutput("issue_count", issued, n_exp);
        if (abort_mode) checkOutput("abort_latency", cyc - rose_cyc, 1);
        prog_we_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      end else begin
        abort_i = 1'b0;
        if (abort_mode && !abort_fired && issued == 1 && busy_left >= 2) begin
          abort_i = 1'b1;
          abort_fired = 1;
        end
        unitTick(cyc);
        if (noise) begin
          prog_we_i    = ($urandom_range(0, 2) == 0);
          prog_addr_i  = 8'($urandom);
          prog_data_i  = 18'($urandom);
          start_i      = ($urandom_range(0, 3) == 0);
          start_addr_i = 8'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!got_done) begin
      checkOutput("done_timeout", got_done, 1);
      applyReset();
    end else begin
      @(negedge clk);
      checkOutput("done_pulse", done_o, 0);
      checkOutput("idle_after_done", busy_o, 0);
    end
  endtask

  // Random program built from blocks that always terminate: EXEC, forward
  // branch/jump to a block start, or SETCNT/EXEC/LOOP with count 1..3
  task automatic genProgram(input logic [7:0] base);
    int n, a, t;
    int kind [8];
    int st [9];
    logic [2:0] bop;
    n = $urandom_range(3, 7);
    a = int'(base);
    for (int i = 0; i < n; i++) begin
      kind[i] = $urandom_range(0, 4);
      st[i] = a;
      a += (kind[i] == 4) ? 3 : 1;
    end
    st[n] = a;
    for (int i = 0; i < n; i++) begin
      t = st[$urandom_range(i + 1, n)];
      case (kind[i])
        0, 1: loadWord(8'(st[i]), {OP_EXEC, 15'($urandom)});
        2: begin
          bop = ($urandom_range(0, 1) == 0) ? OP_BRZ : OP_BRNZ;
          loadWord(8'(st[i]), {bop, 7'($urandom), 8'(t)});
        end
        3: loadWord(8'(st[i]), {OP_JMP, 7'($urandom), 8'(t)});
        default: begin
          loadWord(8'(st[i]),     {OP_SETCNT, 15'($urandom_range(1, 3))});
          loadWord(8'(st[i] + 1), {OP_EXEC, 15'($urandom)});
          loadWord(8'(st[i] + 2), {OP_LOOP, 7'($urandom), 8'(st[i] + 1)});
        end
      endcase
    end
    if ($urandom_range(0, 5) == 0) loadWord(8'(st[n]), {OP_ILL, 15'($urandom)});
    else                           loadWord(8'(st[n]), {OP_HALT, 15'($urandom)});
  endtask

  initial begin
    bit found;
    logic [7:0] base;
    areset = 1'b0;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
    start_i = 1'b0; start_addr_i = '0;
    ex_ready_i = 1'b1; ex_comp_i = 1'b0; abort_i = 1'b0;
    m_cnt = '0;
    busy_left = 0; drop_pend = 0; stall_left = 0; unit_lat = 1; rose_cyc = 0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ex_v", ex_v_o, 0);
    checkOutput("rst_ex_i", ex_i_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_pc", pc_o, 0);
    areset = 1'b1;

    // Single EXEC then HALT; entry word written in the same cycle as start
    $display("[TB] single exec");
    loadWord(8'd1, {OP_HALT, 15'd0});
    applyStimulus(8'd0, 1'b0, 3, 0, 1'b0, 1'b1, 8'd0, {OP_EXEC, 15'h0123}, 1'b0);

    // Hardware loop: three issues
    $display("[TB] loop");
    loadWord(8'd0, {OP_SETCNT, 15'd3});
    loadWord(8'd1, {OP_EXEC, 15'h0800});
    loadWord(8'd2, {OP_LOOP, 15'd1});
    loadWord(8'd3, {OP_HALT, 15'd0});
    applyStimulus(8'd0, 1'b0, 2, 0, 1'b0, 1'b0, 8'd0, 18'd0, 1'b0);

    // BRZ taken with comp=0, falls through with comp=1
    $display("[TB] branch");
    loadWord(8'd20, {OP_BRZ, 15'd25});
    loadWord(8'd21, {OP_EXEC, 15'h0111});
    loadWord(8'd22, {OP_HALT, 15'd0});
    loadWord(8'd25, {OP_EXEC, 15'h0555});
    loadWord(8'd26, {OP_HALT, 15'd0});
    applyStimulus(8'd20, 1'b0, 1, 0, 1'b0, 1'b0, 8'd0, 18'd0, 1'b0);
    applyStimulus(8'd20, 1'b1, 1, 0, 1'b0, 1'b0, 8'd0, 18'd0, 1'b0);

    // Ready held low while the word waits in ISSUE
    $display("[TB] ready stall");
    loadWord(8'd30, {OP_EXEC, 15'h4444});
    loadWord(8'd31, {OP_HALT, 15'd0});
    applyStimulus(8'd30, 1'b0, 2, 13, 1'b0, 1'b0, 8'd0, 18'd0, 1'b0);

    // Abort while the unit is busy: second EXEC must never issue
    $display("[TB] abort");
    loadWord(8'd35, {OP_EXEC, 15'h0AAA});
    loadWord(8'd36, {OP_EXEC, 15'h0BBB});
    loadWord(8'd37, {OP_HALT, 15'd0});
    applyStimulus(8'd35, 1'b0, 4, 0, 1'b1, 1'b0, 8'd0, 18'd0, 1'b0);

    // Illegal opcode
    $display("[TB] illegal opcode");
    loadWord(8'd40, {OP_ILL, 15'h1234});
    applyStimulus(8'd40, 1'b0, 1, 0, 1'b0, 1'b0, 8'd0, 18'd0, 1'b0);

    // EXEC in the last word: issues, then flags the PC overrun
    $display("[TB] pc overrun");
    loadWord(8'd255, {OP_EXEC, 15'h7ABC});
    applyStimulus(8'd255, 1'b0, 2, 0, 1'b0, 1'b0, 8'd0, 18'd0, 1'b0);

    // Random programs with ignored write/start noise while busy
    $display("[TB] random programs");
    for (int r = 0; r < 25; r++) begin
      base = 8'($urandom_range(0, 230));
      genProgram(base);
      applyStimulus(base, 1'($urandom_range(0, 1)), $urandom_range(1, 5),
                    $urandom_range(0, 3), 1'b0, 1'b0, 8'd0, 18'd0, 1'b1);
    end

    // Asynchronous reset in the middle of WAIT_EX
    $display("[TB] reset mid-run");
    loadWord(8'd10, {OP_EXEC, 15'h02AA});
    loadWord(8'd11, {OP_HALT, 15'd0});
    unit_lat = 6; busy_left = 0; drop_pend = 0; stall_left = 0; ex_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1; start_addr_i = 8'd10;
    @(negedge clk);
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      unitTick(c);
      @(negedge clk);
      if (busy_left > 1) found = 1;
    end
    checkOutput("reset_reached_wait", found, 1);
    areset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ex_v", ex_v_o, 0);
    checkOutput("mid_rst_ex_i", ex_i_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_done", done_o, 0);
    checkOutput("mid_rst_pc", pc_o, 0);
    areset = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
